// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory bus, the decoder valid/ack
// handshake, the branch redirect and the register-file PC update.
//   master : fetch unit side (drives mem_req/mem_addr, instr_*, next_pc/pc_en)
//   slave  : environment side (memory, decoder, branch unit, register file)
interface fetch_unit_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned INSTR_W = 16;

    // memory request channel
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_req;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_rdata;

    // decoder handshake
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ack;

    // branch redirect
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;

    // register-file PC sync
    logic [ADDR_W-1:0]  next_pc;
    logic               pc_en;

    modport master (
        output mem_addr, mem_req, instr_out, instr_pc, instr_valid, next_pc, pc_en,
        input  mem_ready, mem_rdata, instr_ack, branch_en, branch_target
    );

    modport slave (
        input  mem_addr, mem_req, instr_out, instr_pc, instr_valid, next_pc, pc_en,
        output mem_ready, mem_rdata, instr_ack, branch_en, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Fetches 32-bit words, selects the
// 16-bit instruction addressed by the fetch PC, hands it to the decoder and
// keeps the register-file PC in sync. Branches redirect fetch and flush.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : fetch_unit_if.master (memory bus, decoder handshake,
//            branch redirect, next_pc/pc_en)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 16;

    // bit 0 of any PC value is always forced to zero
    localparam logic [ADDR_W-1:0] HALF_MASK  = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] BOOT_PC    = RESET_PC & HALF_MASK;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic                 r_mem_req;
    logic                 r_instr_valid;
    logic [INSTR_W-1:0]   r_instr_out;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic [ADDR_W-1:0]    r_next_pc;
    logic                 r_pc_en;

    logic [ADDR_W-1:0]    w_branch_pc;
    logic [ADDR_W-1:0]    w_seq_pc;
    logic [INSTR_W-1:0]   w_half;

    assign w_branch_pc = bus.branch_target & HALF_MASK;
    // 32-bit wrap from 0xFFFF_FFFE to 0 is intentional
    assign w_seq_pc    = r_fetch_pc + PC_STEP;
    // upper halfword when the fetch PC points at the second half of the word
    assign w_half      = r_fetch_pc[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    // state, fetch PC and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_fetch_pc    <= BOOT_PC;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_next_pc     <= '0;
            r_pc_en       <= 1'b0;
        end else begin
            r_pc_en <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    // branch input is ignored while booting
                    r_state   <= ST_FETCH;
                    r_mem_req <= 1'b1;
                    r_pc_en   <= 1'b1;
                    r_next_pc <= BOOT_PC;
                end
                ST_FETCH: begin
                    if (bus.branch_en) begin
                        // redirect; coincident read data is dropped
                        r_fetch_pc <= w_branch_pc;
                        r_next_pc  <= w_branch_pc;
                        r_pc_en    <= 1'b1;
                        r_mem_req  <= 1'b1;
                    end else if (bus.mem_ready) begin
                        r_instr_out   <= w_half;
                        r_instr_pc    <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.branch_en) begin
                        // flush held instruction; coincident ack does not step
                        r_fetch_pc    <= w_branch_pc;
                        r_next_pc     <= w_branch_pc;
                        r_pc_en       <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_mem_req     <= 1'b1;
                        r_state       <= ST_FETCH;
                    end else if (bus.instr_ack) begin
                        r_fetch_pc    <= w_seq_pc;
                        r_next_pc     <= w_seq_pc;
                        r_pc_en       <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_mem_req     <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                default: begin
                    r_state       <= ST_INIT;
                    r_mem_req     <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr    = {r_fetch_pc[ADDR_W-1:2], 2'b00};
    assign bus.mem_req     = r_mem_req;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.next_pc     = r_next_pc;
    assign bus.pc_en       = r_pc_en;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Thumb-style core, directly upstream of `register_file`. Fetches 32-bit words from instruction memory over a req/ready handshake and extracts the 16-bit instruction addressed by the fetch PC. It hands that instruction to the decoder over a valid/ack handshake. It owns the architectural fetch PC and keeps the register file's PC copy in sync through `next_pc`/`pc_en`. Branches redirect fetch and flush any in-flight or held instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset; bit 0 ignored.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  32  word-aligned fetch address, `{fetch_pc[31:2],2'b00}`, combinational from the internal fetch PC.
- `mem_req`  out  1  fetch request.
- `mem_ready`  in  1  memory has valid `mem_rdata` this cycle for the current `mem_addr`.
- `mem_rdata`  in  32  fetched word.
- `instr_out`  out  16  held instruction.
- `instr_pc`  out  32  address of `instr_out`.
- `instr_valid`  out  1  `instr_out` is valid.
- `instr_ack`  in  1  decoder consumes `instr_out` in this cycle; only meaningful while `instr_valid`=1.
- `branch_en`  in  1  redirect fetch this cycle.
- `branch_target`  in  32  redirect address; bit 0 forced to 0.
- `next_pc`  out  32  value for the register file PC; to `register_file.next_pc`.
- `pc_en`  out  1  single-cycle PC write strobe; to `register_file.pc_en`.

## Operation
- Internal register `fetch_pc[31:0]`, always halfword-aligned.
- **States:**
  - **INIT:** entered on reset; `mem_req`=0.
  - **FETCH:** `mem_req`=1.
  - **HOLD:** `instr_valid`=1.
- **INIT → FETCH:** on the first clock edge after reset deasserts. On that edge: `pc_en`<=1, `next_pc`<=`RESET_PC` with bit 0 cleared.
- **FETCH:**
  - On `mem_ready`=1: `instr_out`<= `fetch_pc[1]` ? `mem_rdata[31:16]` : `mem_rdata[15:0]`; `instr_pc`<=`fetch_pc`; go to HOLD.
  - Otherwise stay.
- **HOLD:**
  - On `instr_ack`=1: `fetch_pc`<=`fetch_pc`+2; `pc_en`<=1; `next_pc`<=`fetch_pc`+2; go to FETCH.
  - Otherwise hold all outputs stable.
- **Branch** (`branch_en`=1, in FETCH or HOLD) has priority over `mem_ready` and `instr_ack`:
  - `fetch_pc`<=`{branch_target[31:1],1'b0}`; `pc_en`<=1; `next_pc`<=same value.
  - Go to FETCH; `instr_valid` drops on the next edge.
  - Coincident `mem_rdata` is discarded.
  - A coincident ack is ignored: no +2 increment.
- **Branch in INIT:** ignored.
- **Address change under request:** in FETCH without `mem_ready`, a branch changes `mem_addr` while `mem_req` stays high. Memory must sample the address in the `mem_ready` cycle.
- **Arithmetic:** 32-bit unsigned. `0xFFFF_FFFE`+2 wraps to `0x0000_0000` with no flag.
- **`pc_en`:** high for exactly one cycle per event, otherwise 0. `next_pc` holds its last value when `pc_en`=0.
- **Reset mid-operation:** all state and outputs return to reset values immediately (asynchronous). Any pending memory or decode handshake is abandoned.

## Timing
- **Reset values:**
  - `mem_req`=0, `instr_valid`=0, `pc_en`=0.
  - `instr_out`=0, `instr_pc`=0, `next_pc`=0.
  - `fetch_pc`=`RESET_PC`, so `mem_addr`=`RESET_PC` & ~3.
  - State INIT.
- **Cycle 1 after reset release:** `pc_en`=1 and `mem_req`=1 together.
- **Fetch latency:** `mem_ready` in cycle n → `instr_valid`=1 in cycle n+1. `mem_req` is 0 in cycle n+1.
- **Ack:** ack in cycle n (with `instr_valid`) → in cycle n+1, `instr_valid`=0, `pc_en`=1, `mem_req`=1 at the new address.
- **Throughput:** best case one instruction per 2 cycles with zero-wait memory and immediate ack.
- **Branch:** `branch_en` in cycle n → in cycle n+1, `mem_req`=1 at the target word, `pc_en`=1, `instr_valid`=0.
- `mem_req` never deasserts in FETCH before `mem_ready`.

## Test plan
- **Reset/boot:** `RESET_PC`=0x100; release reset; zero-wait memory returns 0xBBBB_AAAA; ack immediately.
  - Cycle 1: `pc_en`=1, `next_pc`=0x100, `mem_addr`=0x100.
  - Then `instr_out`=0xAAAA, `instr_pc`=0x100.
  - Next fetch: `mem_addr`=0x100, `instr_out`=0xBBBB, `instr_pc`=0x102.
  - Then `mem_addr`=0x104.
- **Wait states:** hold `mem_ready`=0 for 3 cycles.
  - `mem_req` and `mem_addr` stay stable; `instr_valid`=0 throughout.
  - `instr_valid` rises exactly one cycle after `mem_ready`.
- **Decoder stall:** withhold `instr_ack` for 4 cycles.
  - `instr_out`/`instr_pc` stay stable; `mem_req`=0; no `pc_en`.
  - On ack: single `pc_en` pulse with `next_pc`=`instr_pc`+2.
- **Branch precedence:**
  - `branch_en`=1, `branch_target`=0x2003 in the same cycle as `instr_ack` → `next_pc`=0x2002, `mem_addr`=0x2000, no +2.
  - Repeat with `branch_en` coincident with `mem_ready` → data dropped, `instr_valid` stays 0.
- **Wrap:** branch to 0xFFFF_FFFE, fetch, ack → `next_pc`=0x0000_0000, `mem_addr`=0.
- **Reset mid-fetch:** assert `reset` mid-cycle while in HOLD → `instr_valid` and `mem_req` drop immediately without a clock edge; recovery follows the boot scenario.
